// File: rtl/iob_eth_mii_rx_gen.sv
// -----------------------------------------------------------------------------
// iob_eth_mii_rx_gen
//
// PHY-side MII receive-stream generator. On a start pulse it emits a complete
// Ethernet frame as nibbles on RX_DV/RX_DATA:
//   preamble (7 x 0x55), SFD (0xD5), 14-byte header, payload read from a byte
//   buffer, zero pad up to 60 bytes, 4-byte FCS, then a 24-cycle IFG.
// Everything runs in the RX_CLK domain; RX_DV/RX_DATA are registered.
//
// Ports
//   rst       in   async, active-high reset
//   RX_CLK    in   clock
//   start     in   one-cycle frame request, honoured only while idle
//   dest_mac  in   destination MAC, bits [7:0] sent first
//   src_mac   in   source MAC, bits [7:0] sent first
//   nbytes    in   payload length, also sent as the length field
//   addr      out  payload buffer read address
//   rd_data   in   buffer data for addr, sampled on the edge after addr changes
//   RX_DV     out  MII data valid
//   RX_DATA   out  MII nibble (low nibble of each byte first)
//   busy      out  frame or IFG in progress
//   done      out  one-cycle pulse after the IFG
// -----------------------------------------------------------------------------
module iob_eth_mii_rx_gen #(
  parameter int BUF_ADDR_W = 11,
  parameter int DATA_W     = 8
) (
  input  logic                  rst,
  input  logic                  RX_CLK,
  input  logic                  start,
  input  logic [47:0]           dest_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           nbytes,
  output logic [BUF_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  RX_DV,
  output logic [3:0]            RX_DATA,
  output logic                  busy,
  output logic                  done
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [15:0] IFG_LAST = 16'd23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_HEADER,
    S_PAYLOAD,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  // Reflected CRC-32, one nibble, LSB first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // state/cnt/phase describe the nibble currently on RX_DATA.
  state_t                state_q,   state_d;
  logic [15:0]           cnt_q,     cnt_d;
  logic                  phase_q,   phase_d;   // 0: low nibble, 1: high nibble
  logic [111:0]          hdr_q,     hdr_d;     // header, shifted out LSB first
  logic [15:0]           n_q,       n_d;
  logic [7:0]            byte_q,    byte_d;    // byte whose nibbles are being sent
  logic [31:0]           crc_q,     crc_d;
  logic [BUF_ADDR_W-1:0] addr_q,    addr_d;
  logic                  rx_dv_q,   rx_dv_d;
  logic [3:0]            rx_data_q, rx_data_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;

  logic [15:0] pad_len;
  logic [15:0] last_cnt;
  state_t      after_state;
  logic [16:0] next_idx;
  logic [7:0]  next_byte;

  assign pad_len  = (n_q < 16'd46) ? (16'd46 - n_q) : 16'd0;
  assign next_idx = {1'b0, cnt_q} + 17'd1;

  // Last byte index of each byte-oriented state and the state that follows it.
  always_comb begin
    last_cnt    = 16'd0;
    after_state = S_IDLE;
    case (state_q)
      S_PREAMBLE: begin last_cnt = 16'd6;  after_state = S_SFD;    end
      S_SFD:      begin last_cnt = 16'd0;  after_state = S_HEADER; end
      S_HEADER: begin
        last_cnt    = 16'd13;
        after_state = (n_q != 16'd0) ? S_PAYLOAD : S_PAD;
      end
      S_PAYLOAD: begin
        last_cnt    = n_q - 16'd1;
        after_state = (pad_len != 16'd0) ? S_PAD : S_FCS;
      end
      S_PAD:      begin last_cnt = pad_len - 16'd1; after_state = S_FCS; end
      S_FCS:      begin last_cnt = 16'd3;  after_state = S_IFG;    end
      default:    begin last_cnt = 16'd0;  after_state = S_IDLE;   end
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned;
    // otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    hdr_d     = hdr_q;
    n_d       = n_q;
    byte_d    = byte_q;
    crc_d     = crc_q;
    addr_d    = addr_q;
    rx_dv_d   = 1'b0;
    rx_data_d = 4'h0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    next_byte = 8'h00;

    // The CRC absorbs the nibble currently on the wire.
    if (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_PAD) begin
      crc_d = crc_nibble(crc_q, rx_data_q);
    end

    // Advance the frame position.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREAMBLE;
          cnt_d   = 16'd0;
          phase_d = 1'b0;
          hdr_d   = {nbytes[7:0], nbytes[15:8], src_mac, dest_mac};
          n_d     = nbytes;
          crc_d   = CRC_INIT;
          busy_d  = 1'b1;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (cnt_q == last_cnt) begin
            cnt_d   = 16'd0;
            state_d = after_state;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
    endcase

    // Present the next payload address one cycle ahead of its use: during
    // the high nibble of the byte that precedes it.
    if (!phase_q) begin
      if (state_q == S_HEADER && cnt_q == 16'd13 && n_q != 16'd0) begin
        addr_d = '0;
      end else if (state_q == S_PAYLOAD && next_idx < {1'b0, n_q}) begin
        addr_d = BUF_ADDR_W'(next_idx);
      end
    end

    // Byte that starts on the next cycle.
    case (state_d)
      S_PREAMBLE: next_byte = 8'h55;
      S_SFD:      next_byte = 8'hD5;
      S_HEADER:   next_byte = hdr_q[7:0];
      S_PAYLOAD:  next_byte = rd_data[7:0];
      S_FCS: begin
        case (cnt_d[1:0])
          2'd0:    next_byte = ~crc_d[7:0];
          2'd1:    next_byte = ~crc_d[15:8];
          2'd2:    next_byte = ~crc_d[23:16];
          default: next_byte = ~crc_d[31:24];
        endcase
      end
      default:    next_byte = 8'h00;
    endcase

    if (state_d != S_IDLE && state_d != S_IFG) begin
      rx_dv_d = 1'b1;
      if (!phase_d) begin
        byte_d    = next_byte;
        rx_data_d = next_byte[3:0];
        if (state_d == S_HEADER) begin
          hdr_d = hdr_q >> 8;
        end
      end else begin
        rx_data_d = byte_q[7:4];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      phase_q   <= 1'b0;
      hdr_q     <= '0;
      n_q       <= 16'd0;
      byte_q    <= 8'h00;
      crc_q     <= CRC_INIT;
      addr_q    <= '0;
      rx_dv_q   <= 1'b0;
      rx_data_q <= 4'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hdr_q     <= hdr_d;
      n_q       <= n_d;
      byte_q    <= byte_d;
      crc_q     <= crc_d;
      addr_q    <= addr_d;
      rx_dv_q   <= rx_dv_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign addr    = addr_q;
  assign RX_DV   = rx_dv_q;
  assign RX_DATA = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_gen.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_mii_rx_gen
//
// Scoreboard bench for iob_eth_mii_rx_gen. Each start pushes the frame a
// byte-level reference model expects (nibbles and RX_DV length) into queues;
// an independent monitor on the falling edge pops and compares every nibble,
// checks frame length, FCS residue, IFG length and the done pulse.
// -----------------------------------------------------------------------------
module tb_iob_eth_mii_rx_gen;

  localparam int BUF_ADDR_W = 11;
  localparam int BUF_DEPTH  = 1 << BUF_ADDR_W;

  logic                  rst;
  logic                  RX_CLK;
  logic                  start;
  logic [47:0]           dest_mac;
  logic [47:0]           src_mac;
  logic [15:0]           nbytes;
  logic [BUF_ADDR_W-1:0] addr;
  logic [7:0]            rd_data;
  logic                  RX_DV;
  logic [3:0]            RX_DATA;
  logic                  busy;
  logic                  done;

  logic [7:0] mem [BUF_DEPTH];

  // Buffer model: data for the registered address is available for the
  // generator to sample on the following edge.
  assign rd_data = mem[addr];

  iob_eth_mii_rx_gen #(.BUF_ADDR_W(BUF_ADDR_W), .DATA_W(8)) dut (
    .rst      (rst),
    .RX_CLK   (RX_CLK),
    .start    (start),
    .dest_mac (dest_mac),
    .src_mac  (src_mac),
    .nbytes   (nbytes),
    .addr     (addr),
    .rd_data  (rd_data),
    .RX_DV    (RX_DV),
    .RX_DATA  (RX_DATA),
    .busy     (busy),
    .done     (done)
  );

  initial RX_CLK = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  int         exp_len_q[$];
  int         done_cnt = 0;
  int         done_target = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Reference model: whole frame as bytes, then nibbles into the scoreboard.
  task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] n);
    logic [7:0]  fb[$];
    logic [31:0] c;
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fb.push_back(d[8*i +: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(s[8*i +: 8]);
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    for (int k = 0; k < int'(n); k++) fb.push_back(mem[k % BUF_DEPTH]);
    while (fb.size() < 8 + 60) fb.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < fb.size(); i++) c = crc_byte(c, fb[i]);
    c = ~c;
    for (int j = 0; j < 4; j++) fb.push_back(c[8*j +: 8]);
    foreach (fb[i]) begin
      exp_q.push_back(fb[i][3:0]);
      exp_q.push_back(fb[i][7:4]);
    end
    exp_len_q.push_back(2 * fb.size());
  endtask

  // ---------------------------------------------------------------- monitor
  int         run_len = 0;
  int         gap = 0;
  logic       in_frame = 1'b0;
  logic       half = 1'b0;
  logic       prev_done = 1'b0;
  logic [3:0] lo_nib;
  logic [7:0] rx_bytes[$];

  always @(negedge RX_CLK) begin
    if (rst) begin
      run_len   = 0;
      gap       = 0;
      in_frame  = 1'b0;
      half      = 1'b0;
      prev_done = 1'b0;
      rx_bytes.delete();
    end else begin
      if (RX_DV) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          run_len  = 0;
          half     = 1'b0;
          rx_bytes.delete();
        end
        run_len++;
        gap = 0;
        if (exp_q.size() == 0) check("nibble_avail", exp_q.size(), 1);
        else check("nibble", RX_DATA, exp_q.pop_front());
        if (!half) begin
          lo_nib = RX_DATA;
          half   = 1'b1;
        end else begin
          rx_bytes.push_back({RX_DATA, lo_nib});
          half = 1'b0;
        end
      end else begin
        if (in_frame) begin
          logic [31:0] res;
          in_frame = 1'b0;
          if (exp_len_q.size() == 0) check("len_avail", exp_len_q.size(), 1);
          else check("frame_len", run_len, exp_len_q.pop_front());
          res = 32'hFFFFFFFF;
          for (int i = 8; i < rx_bytes.size(); i++) res = crc_byte(res, rx_bytes[i]);
          // 0xDEBB20E3 is the reflected form of the 0xC704DD7B residue.
          check("fcs_residue", res, 32'hDEBB20E3);
        end
        if (done) begin
          done_cnt++;
          check("ifg_len", gap, 24);
          check("busy_at_done", busy, 1'b0);
          check("done_width", prev_done, 1'b0);
        end else if (busy) begin
          gap++;
          check("ifg_data", RX_DATA, 4'h0);
        end
      end
      prev_done = done;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic send(input logic [47:0] d, input logic [47:0] s, input logic [15:0] n);
    push_frame(d, s, n);
    done_target++;
    @(negedge RX_CLK);
    dest_mac = d;
    src_mac  = s;
    nbytes   = n;
    start    = 1'b1;
    @(negedge RX_CLK);
    start = 1'b0;
    check("first_dv", RX_DV, 1'b1);
    check("busy_set", busy, 1'b1);
    // Inputs are latched at start; scrambling them must not matter.
    dest_mac = {$urandom, $urandom};
    src_mac  = {$urandom, $urandom};
    nbytes   = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge RX_CLK);
      if (done_cnt >= done_target) break;
    end
    check("done_seen", done_cnt, done_target);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run(input logic [47:0] d, input logic [47:0] s, input logic [15:0] n);
    send(d, s, n);
    wait_done(2 * (26 + ((n > 46) ? int'(n) : 46)) + 100);
  endtask

  task automatic fill_random;
    for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int saved;
    rst      = 1'b0;
    start    = 1'b0;
    dest_mac = '0;
    src_mac  = '0;
    nbytes   = '0;
    fill_random();
    #1 rst = 1'b1;
    #3;
    check("rst_dv",   RX_DV,   1'b0);
    check("rst_data", RX_DATA, 4'h0);
    check("rst_addr", addr,    '0);
    check("rst_busy", busy,    1'b0);
    check("rst_done", done,    1'b0);
    repeat (3) @(negedge RX_CLK);
    rst = 1'b0;
    repeat (2) @(negedge RX_CLK);

    // Empty payload: full pad.
    run(48'h0A0B0C0D0E0F, 48'h102030405060, 16'd0);

    // Incrementing buffer, 64 bytes, no pad.
    for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'(i);
    run(48'h665544332211, 48'hAABBCCDDEEFF, 16'd64);

    // Random payloads around the pad boundary.
    fill_random();
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'd100);
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'd46);
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'd45);
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'd1);
    for (int t = 0; t < 3; t++) begin
      run({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom_range(0, 200)));
    end

    // Extra starts during PAYLOAD and during IFG are ignored.
    send({$urandom, $urandom}, {$urandom, $urandom}, 16'd50);
    repeat (60) @(negedge RX_CLK);
    start = 1'b1;
    @(negedge RX_CLK);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy && !RX_DV) break;
      @(negedge RX_CLK);
    end
    check("in_ifg", {busy, RX_DV}, 2'b10);
    start = 1'b1;
    @(negedge RX_CLK);
    start = 1'b0;
    wait_done(200);
    saved = done_cnt;
    repeat (200) @(negedge RX_CLK);
    check("no_extra_done", done_cnt, saved);

    // Reset in the middle of PAYLOAD.
    send({$urandom, $urandom}, {$urandom, $urandom}, 16'd50);
    repeat (64) @(negedge RX_CLK);
    #2 rst = 1'b1;
    #1;
    check("midrst_dv",   RX_DV, 1'b0);
    check("midrst_busy", busy,  1'b0);
    check("midrst_done", done,  1'b0);
    exp_q.delete();
    exp_len_q.delete();
    done_target--;
    saved = done_cnt;
    repeat (3) @(negedge RX_CLK);
    #1 rst = 1'b0;
    repeat (40) @(negedge RX_CLK);
    check("midrst_idle_dv", RX_DV, 1'b0);
    check("midrst_no_done", done_cnt, saved);
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'd30);

    // Payload longer than the buffer: address wraps.
    fill_random();
    run({$urandom, $urandom}, {$urandom, $urandom}, 16'(BUF_DEPTH + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
